// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit for an RV32M-style core.
//
// One op runs at a time. A multiply takes 32 shift-add steps. A divide or
// remainder takes 32 restoring shift-subtract steps. Every op has the same
// latency: start is sampled at edge N and done pulses in cycle N+33.
//
// Configuration macro: MULDIV_DIV_EN
//   defined   : all eight funct3 ops are built (MUL..REMU).
//   undefined : no divider hardware. funct3[2]=1 ops go straight to DONE,
//               pulse done/illegal one cycle after start, and return 0.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   op request, only looked at while idle
//   funct3    in   op select (000 MUL .. 111 REMU)
//   rs1_data  in   operand A (multiplicand / dividend)
//   rs2_data  in   operand B (multiplier / divisor)
//   rd_addr   in   destination register, captured with start
//   kill      in   synchronous abort of the op in flight
//   busy      out  op in flight (RUN or DONE)
//   done      out  one-cycle completion pulse
//   result    out  write-back data, holds between done pulses
//   rd_out    out  destination register of the last completed op
//   we_out    out  register file write enable (equals done)
//   illegal   out  pulses with done for ops that are not built
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        we_out,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic        neg_q;
  logic [31:0] mcand_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [4:0]  rd_q;
`ifdef MULDIV_DIV_EN
  logic        dz_q;
`endif

  logic        accept;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod_fix;
  logic [31:0] final_result;
`ifdef MULDIV_DIV_EN
  logic [33:0] rem_diff;
  logic        rem_ok;
`endif

  assign accept = (state_q == IDLE) && start && !kill;

  // Operand sign handling: the datapath works on magnitudes, and the sign of
  // the answer is restored at the end. MULHSU treats rs2 as unsigned.
  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed && rs1_data[31];
    b_neg    = b_signed && rs2_data[31];
    a_mag    = a_neg ? (32'd0 - rs1_data) : rs1_data;
    b_mag    = b_neg ? (32'd0 - rs2_data) : rs2_data;
  end

  // One iteration step. For multiply, {hi,lo} is the product/multiplier
  // shift register. For divide, hi is the partial remainder and lo shifts the
  // dividend out while the quotient bits shift in.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);
    step_hi = mul_sum[32:1];
    step_lo = {mul_sum[0], lo_q[31:1]};
`ifdef MULDIV_DIV_EN
    rem_diff = {1'b0, hi_q, lo_q[31]} - {2'b00, mcand_q};
    // A successful subtract always leaves a value below the divisor, so
    // bits 33 and 32 are both clear exactly when no borrow occurred.
    rem_ok = ~|rem_diff[33:32];
    if (op_q[2]) begin
      if (rem_ok) begin
        step_hi = rem_diff[31:0];
        step_lo = {lo_q[30:0], 1'b1};
      end else begin
        step_hi = {hi_q[30:0], lo_q[31]};
        step_lo = {lo_q[30:0], 1'b0};
      end
    end
`endif
  end

  // Value written back after the last step. Divide by zero yields all ones
  // for the quotient, and the restoring loop already yields the dividend as
  // the remainder. The signed overflow case falls out of the magnitude math.
  always_comb begin
    prod_fix     = neg_q ? (64'd0 - {step_hi, step_lo}) : {step_hi, step_lo};
    final_result = (op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
`ifdef MULDIV_DIV_EN
    if (op_q[2]) begin
      if (op_q[1])
        final_result = neg_q ? (32'd0 - step_hi) : step_hi;
      else if (dz_q)
        final_result = 32'hFFFF_FFFF;
      else
        final_result = neg_q ? (32'd0 - step_lo) : step_lo;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic. Kill wins over start in IDLE and aborts RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef MULDIV_DIV_EN
          state_d = RUN;
`else
          state_d = funct3[2] ? DONE : RUN;
`endif
        end
      end
      RUN: begin
        if (kill)
          state_d = IDLE;
        else if (cnt_q == 5'd31)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration and write-back registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      neg_q   <= 1'b0;
      mcand_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      rd_q    <= 5'd0;
      result  <= 32'd0;
      rd_out  <= 5'd0;
`ifdef MULDIV_DIV_EN
      dz_q    <= 1'b0;
`endif
    end else if (accept) begin
      op_q  <= funct3;
      rd_q  <= rd_addr;
      cnt_q <= 5'd0;
      hi_q  <= 32'd0;
      neg_q <= (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
`ifdef MULDIV_DIV_EN
      dz_q <= (rs2_data == 32'd0);
      if (funct3[2]) begin
        mcand_q <= b_mag;
        lo_q    <= a_mag;
      end else begin
        mcand_q <= a_mag;
        lo_q    <= b_mag;
      end
`else
      mcand_q <= a_mag;
      lo_q    <= b_mag;
      // Unbuilt ops complete next cycle, so their write-back is set now.
      if (funct3[2]) begin
        result <= 32'd0;
        rd_out <= rd_addr;
      end
`endif
    end else if (state_q == RUN && !kill) begin
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        result <= final_result;
        rd_out <= rd_q;
      end
    end
  end

  // A kill arriving in DONE also suppresses that cycle's pulse.
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE) && !kill;
  assign we_out = done;
`ifdef MULDIV_DIV_EN
  assign illegal = 1'b0;
`else
  assign illegal = done && op_q[2];
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// Vector table, hand sequences for start-while-busy, kill and mid-op reset,
// then random ops against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic        kill = 1'b0;
  logic        busy, done, we_out, illegal;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_addr  (rd_addr),
    .kill     (kill),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out),
    .we_out   (we_out),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Reference model straight from the arithmetic definition of each op.
  function automatic logic [31:0] refModel(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = 64'($signed(a));
    sb  = 64'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 :
                   32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Launch one op from idle and wait (bounded) for its done pulse.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               output int lat);
    start    = 1'b1;
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    rd_addr  = rd;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic checkOp(input string name, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_full);
    logic [31:0] exp_res;
    logic        exp_ill;
    int          exp_lat;
    int          lat;
`ifdef MULDIV_DIV_EN
    exp_res = exp_full;
    exp_ill = 1'b0;
    exp_lat = 33;
`else
    exp_ill = f3[2];
    exp_res = f3[2] ? 32'd0 : exp_full;
    exp_lat = f3[2] ? 1 : 33;
`endif
    applyStimulus(f3, a, b, rd, lat);
    checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, "_done"}, 32'(done), 32'd1);
    checkOutput({name, "_result"}, result, exp_res);
    checkOutput({name, "_rd"}, 32'(rd_out), 32'(rd));
    checkOutput({name, "_we"}, 32'(we_out), 32'd1);
    checkOutput({name, "_illegal"}, 32'(illegal), 32'(exp_ill));
    tick();
    checkOutput({name, "_idle"}, 32'(busy), 32'd0);
    checkOutput({name, "_hold"}, result, exp_res);
    checkOutput({name, "_rdhold"}, 32'(rd_out), 32'(rd));
  endtask

  initial begin
    int lat;
    int kdone;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;

    vecs[0]  = '{3'd0, 32'd10, 32'd5, 5'd3, 32'd50};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'd0};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd0, 32'hFFFF_FFFD, 32'd7, 5'd7, 32'hFFFF_FFEB};
    vecs[5]  = '{3'd4, 32'd100, 32'd0, 5'd8, 32'hFFFF_FFFF};
    vecs[6]  = '{3'd6, 32'd100, 32'd0, 5'd9, 32'd100};
    vecs[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000};
    vecs[8]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF};
    vecs[9]  = '{3'd5, 32'd7, 32'd2, 5'd12, 32'd3};
    vecs[10] = '{3'd7, 32'd7, 32'd2, 5'd13, 32'd1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0};

    // Reset state.
    #1 rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_we", 32'(we_out), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_rd", 32'(rd_out), 32'd0);
    rst = 1'b0;

    // Vector table; the first op starts on the first edge after reset.
    for (int i = 0; i < 12; i++)
      checkOp($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
              vecs[i].rd, vecs[i].exp);

    // Start while busy is ignored.
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd7; rs2_data = 32'd6; rd_addr = 5'd20;
    tick();
    start = 1'b0;
    lat = 1;
    repeat (3) begin tick(); lat++; end
    start = 1'b1; funct3 = 3'd3; rs1_data = 32'd100; rs2_data = 32'd100; rd_addr = 5'd21;
    tick();
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin tick(); lat++; end
    checkOutput("busy_start_latency", 32'(lat), 32'd33);
    checkOutput("busy_start_result", result, 32'd42);
    checkOutput("busy_start_rd", 32'(rd_out), 32'd20);
    tick();
    checkOutput("busy_start_idle", 32'(busy), 32'd0);

    // Kill in RUN, then a fresh op right after.
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_addr = 5'd22;
    tick();
    start = 1'b0;
    kdone = 0;
    repeat (8) begin tick(); if (done) kdone++; end
    kill = 1'b1;
    tick();
    kill = 1'b0;
    checkOutput("kill_busy", 32'(busy), 32'd0);
    tick();
    if (done) kdone++;
    checkOutput("kill_no_done", 32'(kdone), 32'd0);
    checkOp("after_kill", 3'd0, 32'd11, 32'd12, 5'd23, 32'd132);

    // Kill in IDLE beats start.
    kill = 1'b1; start = 1'b1; funct3 = 3'd0;
    tick();
    kill = 1'b0; start = 1'b0;
    checkOutput("kill_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-op.
    start = 1'b1; funct3 = 3'd1; rs1_data = 32'd1234; rs2_data = 32'd77; rd_addr = 5'd24;
    tick();
    start = 1'b0;
    repeat (14) tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    checkOutput("arst_result", result, 32'd0);
    checkOutput("arst_rd", 32'(rd_out), 32'd0);
    checkOutput("arst_we", 32'(we_out), 32'd0);
    tick();
    rst = 1'b0;
    checkOp("after_rst_divu", 3'd5, 32'd1000, 32'd7, 5'd25, 32'd142);

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom);
      if (i % 6 == 1) b = 32'd0;
      if (i % 9 == 2) b = 32'hFFFF_FFFF;
      if (i % 8 == 3) a = 32'h8000_0000;
      if (i % 5 == 4) b = 32'($urandom_range(1, 300));
      checkOp($sformatf("rand%0d", i), f3, a, b, rd, refModel(f3, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; datapath fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data  input  32  operand A (multiplicand/dividend), from register file read port 1.
REQ-007 rs2_data  input  32  operand B (multiplier/divisor), from register file read port 2.
REQ-008 rd_addr  input  5  destination register, latched with start.
REQ-009 kill  input  1  synchronous abort of in-flight op.
REQ-010 busy  output  1  high while an op is in flight, DONE state included.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  32  write-back data to register file wdata.
REQ-013 rd_out  output  5  latched rd_addr, to register file rd_addr.
REQ-014 we_out  output  1  equals done; drives register file we.
REQ-015 illegal  output  1  one-cycle pulse with done when op not supported (see REQ-032).

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-017 IDLE: start=1 latches funct3, rs1_data, rs2_data, rd_addr; next state RUN; counter cleared to 0.
REQ-018 RUN: one shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) step per cycle; exactly 32 steps; after step 32 -> DONE.
REQ-019 DONE: done=1, we_out=1, result and rd_out valid for that one cycle; next state IDLE.
REQ-020 Latency fixed for every op: start sampled at edge N; done high in cycle N+33; busy high in cycles N+1 through N+33.
REQ-021 start while busy SHALL be ignored; latched operands unchanged.
REQ-022 Signed ops use magnitudes internally, then negate the result: MULH/DIV by XOR of the operand signs, REM by the dividend sign; MULHSU treats rs2 as unsigned.
REQ-023 MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32] of the 64-bit product.
REQ-024 Divide by zero: DIV/DIVU result 32'hFFFFFFFF, REM/REMU result = dividend; same latency.
REQ-025 Signed overflow 32'h80000000 / 32'hFFFFFFFF: DIV result 32'h80000000, REM result 0.
REQ-026 kill=1 in RUN or DONE -> IDLE next cycle; done/we_out SHALL NOT assert for the killed op; kill in IDLE has no effect and has priority over start.
REQ-027 result, rd_out SHALL hold their last values between done pulses.

Reset
REQ-028 rst asserted SHALL force IDLE asynchronously, mid-operation included.
REQ-029 Reset values: busy=0, done=0, we_out=0, illegal=0, result=0, rd_out=0, counter=0.
REQ-030 First start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro MULDIV_DIV_EN defined: all eight ops are implemented per REQ-016..027.
REQ-032 Macro MULDIV_DIV_EN undefined: no divider logic is built; funct3[2]=1 ops skip RUN, going IDLE -> DONE; done, we_out and illegal are high in cycle N+1; result=0.

Verification
REQ-033 MUL rs1=10, rs2=5, rd=3 -> done at N+33, result=50, rd_out=3, we_out=1.
REQ-034 MULH rs1=32'hFFFFFFFF, rs2=32'hFFFFFFFF -> result=0; MULHU with the same operands -> result=32'hFFFFFFFE.
REQ-035 DIV 100/0 -> 32'hFFFFFFFF; REM 100/0 -> 100; DIV 32'h80000000/32'hFFFFFFFF -> 32'h80000000; REM -7/2 -> 32'hFFFFFFFF.
REQ-036 Second start at N+5 with different operands -> ignored; the first op's result appears at N+33.
REQ-037 kill at N+10 -> no done pulse; new start at N+12 -> done at N+45.
REQ-038 rst pulsed at N+15 -> all outputs 0 and busy=0 immediately; with MULDIV_DIV_EN undefined, DIVU -> done and illegal at N+1, result=0.
